breakout_ball_ctrl: RTL and testbench
=====================================

# breakout_ball_ctrl

Ball motion controller for the Breakout playfield: owns ball position and direction and drives the four ball edge buses (left, right, top, bottom) to every block column and to the renderer. It consumes the one-cycle moveU/moveD/moveL/moveR bounce requests that the block columns raise on a hit, merges them with wall and paddle collisions, and advances the ball once per frame tick. It also runs the serve/miss/lives state machine.

## Interface
- BALL_SIZE, 8: ball edge length in px; x_r = x_l + BALL_SIZE − 1, y_b = y_t + BALL_SIZE − 1.
- BALL_V, 2: px moved per axis per frame tick. Must be ≤ 3 so it never skips a block's 4-px side/edge hit window.
- PADDLE_Y, 570: paddle top row.
- LIVES, 3: lives at reset, 2-bit counter.
- clk  in  1  system pixel clock.
- reset  in  1  asynchronous, active-high; all state is cleared immediately.
- frame_tick  in  1  one-cycle pulse once per frame, issued during vertical blank.
- launch  in  1  debounced one-cycle serve request.
- moveU, moveD, moveL, moveR  in  1 each  bounce requests, already OR-reduced across all block columns.
- paddle_x_l, paddle_x_r  in  11 each  paddle horizontal extent.
- pix_x, pix_y  in  11 each  current scan pixel.
- ball_x_l, ball_x_r, ball_y_t, ball_y_b  out  11 each  registered ball edges.
- ball_on  out  1  pixel lies inside the ball; combinational from pix_* and the edge registers.
- lives  out  2  lives remaining.
- game_over  out  1  high while in GAME_OVER.

## Operation
- States: SERVE, PLAY, MISS, GAME_OVER. Reset enters SERVE with x_l = 396, y_t = PADDLE_Y − BALL_SIZE, dx = +1, dy = −1 (up), lives = LIVES, and all pending flags cleared.
- SERVE: on each frame_tick, x_l = ((paddle_x_l + paddle_x_r) >> 1) − BALL_SIZE/2, with the sum computed at 12 bits, and y_t is held. launch moves to PLAY with dx = +1, dy = −1.
- PLAY, bounce latch: any move* pulse sets its pending flag. Flags are sticky until the next frame_tick. A move* pulse that arrives on the tick cycle is included in that tick.
- PLAY, on frame_tick, direction updates are evaluated first:
  - pendR → dx = +1; pendL → dx = −1; both set → dx = −dx.
  - pendD → dy = +1; pendU → dy = −1; both set → dy = −dy.
  - Walls (they override block requests on the same axis): x_l ≤ BALL_V with dx < 0 → dx = +1; x_r ≥ 799 − BALL_V with dx > 0 → dx = −1; y_t ≤ BALL_V with dy < 0 → dy = +1.
  - Paddle: dy > 0, y_b in [PADDLE_Y − BALL_V, PADDLE_Y], and x_r ≥ paddle_x_l and x_l ≤ paddle_x_r → dy = −1. Paddle overrides pendD.
- PLAY, position update: the move then uses the new direction in the same tick. x_l ± BALL_V is clamped to [0, 800 − BALL_SIZE]. y_t + BALL_V has no clamp. y_t − BALL_V is clamped at 0.
- PLAY, miss detection: if the new y_t > 599, go to MISS. All pending flags clear on every tick.
- MISS: lasts exactly one cycle. lives decrements. If the new lives = 0, go to GAME_OVER; otherwise go to SERVE with the reset position/direction values.
- GAME_OVER: ball frozen, move* and launch ignored, game_over = 1. Only reset exits.
- Outside PLAY: move* pulses are ignored and do not set pending flags.

## Timing
- Edge outputs change only on the cycle after a frame_tick (in PLAY or SERVE), or on MISS → SERVE.
- Edges are registered. x_r and y_b are registered copies updated together with x_l and y_t, never one cycle stale.
- A bounce pulse at cycle n affects the position at the first frame_tick ≥ n.
- launch and frame_tick in the same cycle: the state moves to PLAY; no motion occurs on that tick.
- lives saturates at 0 and never wraps.
- Reset asserted mid-frame: outputs take their reset values asynchronously. frame_tick is ignored while reset is high.

## Structure
- breakout_pkg holds:
  - screen constants: H_MAX = 799, V_MAX = 599;
  - the state enum: SERVE/PLAY/MISS/GAME_OVER;
  - the shared 11-bit coordinate width.
- Sub-module breakout_bounce_latch holds the four sticky pending flags, their set-on-pulse / clear-on-tick logic and the both-set resolution. Its outputs are the resolved dx and dy requests.

## Test plan
- Reset, then tick with paddle 360..440 → x_l = 396, y_t = 562, lives = 3, state SERVE.
- launch, then 1 tick → state PLAY, no motion on that tick. Next tick → x_l = 398, y_t = 560.
- In PLAY with dx = +1, pulse moveL 5 cycles before a tick → x_l decreases by 2 on that tick. A second tick without a pulse continues left (pending flag was cleared).
- moveL and moveR in the same frame with dx = −1 → dx = +1.
- Ball with dy = +1 at y_b = 569, x inside the paddle → dy = −1 and y_t decreases. Same ball with x outside the paddle → falls through, y_t > 599 → MISS, lives 3 → 2, then SERVE.
- lives = 1 and a miss → game_over = 1. Further ticks, launch and move* → edges unchanged. Asynchronous reset → lives = 3, game_over = 0.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared playfield constants, coordinate type and ball-controller state encoding.
package breakout_pkg;
  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t H_MAX = 11'd799;
  localparam coord_t V_MAX = 11'd599;

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    MISS      = 2'd2,
    GAME_OVER = 2'd3
  } state_t;
endpackage

// File: rtl/breakout_bounce_latch.sv
// Sticky bounce-request flags, cleared each frame tick; a pulse on the tick cycle still counts.
// Resolves opposing requests on one axis into a reversal of the current direction.
module breakout_bounce_latch (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic frame_tick,
  input  logic move_u,
  input  logic move_d,
  input  logic move_l,
  input  logic move_r,
  input  logic dx_pos,
  input  logic dy_down,
  output logic dx_pos_req,
  output logic dy_down_req
);
  logic pend_u, pend_d, pend_l, pend_r;
  logic eff_u, eff_d, eff_l, eff_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_u <= 1'b0;
      pend_d <= 1'b0;
      pend_l <= 1'b0;
      pend_r <= 1'b0;
    end else if (frame_tick) begin
      pend_u <= 1'b0;
      pend_d <= 1'b0;
      pend_l <= 1'b0;
      pend_r <= 1'b0;
    end else if (enable) begin
      pend_u <= pend_u | move_u;
      pend_d <= pend_d | move_d;
      pend_l <= pend_l | move_l;
      pend_r <= pend_r | move_r;
    end
  end

  assign eff_u = pend_u | (enable & move_u);
  assign eff_d = pend_d | (enable & move_d);
  assign eff_l = pend_l | (enable & move_l);
  assign eff_r = pend_r | (enable & move_r);

  always_comb begin
    dx_pos_req = dx_pos;
    if (eff_r && eff_l) dx_pos_req = ~dx_pos;
    else if (eff_r)     dx_pos_req = 1'b1;
    else if (eff_l)     dx_pos_req = 1'b0;

    dy_down_req = dy_down;
    if (eff_d && eff_u) dy_down_req = ~dy_down;
    else if (eff_d)     dy_down_req = 1'b1;
    else if (eff_u)     dy_down_req = 1'b0;
  end
endmodule

// File: rtl/breakout_ball_ctrl.sv
// Ball position/direction owner: merges block, wall and paddle bounces, moves once per frame tick.
// Runs serve/miss/lives sequencing; ball edges are registered and change only after a tick or a re-serve.
module breakout_ball_ctrl
  import breakout_pkg::*;
#(
  parameter int BALL_SIZE = 8,
  parameter int BALL_V    = 2,
  parameter int PADDLE_Y  = 570,
  parameter int LIVES     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        launch,
  input  logic        moveU,
  input  logic        moveD,
  input  logic        moveL,
  input  logic        moveR,
  input  logic [10:0] paddle_x_l,
  input  logic [10:0] paddle_x_r,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  output logic [10:0] ball_x_l,
  output logic [10:0] ball_x_r,
  output logic [10:0] ball_y_t,
  output logic [10:0] ball_y_b,
  output logic        ball_on,
  output logic [1:0]  lives,
  output logic        game_over
);
  localparam coord_t      SZ_M1   = coord_t'(BALL_SIZE - 1);
  localparam coord_t      VEL     = coord_t'(BALL_V);
  localparam coord_t      X_MAX   = coord_t'(int'(H_MAX) + 1 - BALL_SIZE);
  localparam coord_t      X_WALL  = H_MAX - VEL;
  localparam coord_t      PAD_TOP = coord_t'(PADDLE_Y);
  localparam coord_t      PAD_WIN = coord_t'(PADDLE_Y - BALL_V);
  localparam coord_t      SERVE_X = 11'd396;
  localparam coord_t      SERVE_Y = coord_t'(PADDLE_Y - BALL_SIZE);
  localparam logic [11:0] HALF    = 12'(BALL_SIZE / 2);

  state_t state, state_nxt;
  logic   dx_pos, dy_down;
  logic   dx_req, dy_req;
  logic   dx_n, dy_n;
  logic   play_en;
  coord_t x_step, nx, ny, serve_x;

  breakout_bounce_latch u_bounce (
    .clk        (clk),
    .reset      (reset),
    .enable     (play_en),
    .frame_tick (frame_tick),
    .move_u     (moveU),
    .move_d     (moveD),
    .move_l     (moveL),
    .move_r     (moveR),
    .dx_pos     (dx_pos),
    .dy_down    (dy_down),
    .dx_pos_req (dx_req),
    .dy_down_req(dy_req)
  );

  // Sum kept at 12 bits so a paddle near the right edge cannot wrap the centre.
  assign serve_x = coord_t'((({1'b0, paddle_x_l} + {1'b0, paddle_x_r}) >> 1) - HALF);

  // Walls override block requests; the paddle is applied last so it beats a pending down.
  always_comb begin
    dx_n = dx_req;
    dy_n = dy_req;
    if (!dx_n && ball_x_l <= VEL)      dx_n = 1'b1;
    else if (dx_n && ball_x_r >= X_WALL) dx_n = 1'b0;
    if (!dy_n && ball_y_t <= VEL) dy_n = 1'b1;
    if (dy_n && ball_y_b >= PAD_WIN && ball_y_b <= PAD_TOP &&
        ball_x_r >= paddle_x_l && ball_x_l <= paddle_x_r)
      dy_n = 1'b0;

    if (dx_n) x_step = ball_x_l + VEL;
    else      x_step = (ball_x_l < VEL) ? '0 : ball_x_l - VEL;
    nx = (x_step > X_MAX) ? X_MAX : x_step;
    ny = dy_n ? ball_y_t + VEL : ((ball_y_t < VEL) ? '0 : ball_y_t - VEL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SERVE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SERVE:     if (launch) state_nxt = PLAY;
      PLAY:      if (frame_tick && ny > V_MAX) state_nxt = MISS;
      MISS:      state_nxt = (lives <= 2'd1) ? GAME_OVER : SERVE;
      GAME_OVER: state_nxt = GAME_OVER;
      default:   state_nxt = SERVE;
    endcase
  end

  always_comb begin
    play_en   = (state == PLAY);
    game_over = (state == GAME_OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_x_l <= SERVE_X;
      ball_x_r <= SERVE_X + SZ_M1;
      ball_y_t <= SERVE_Y;
      ball_y_b <= SERVE_Y + SZ_M1;
      dx_pos   <= 1'b1;
      dy_down  <= 1'b0;
      lives    <= 2'(LIVES);
    end else begin
      case (state)
        SERVE: begin
          if (launch) begin
            dx_pos  <= 1'b1;
            dy_down <= 1'b0;
          end else if (frame_tick) begin
            ball_x_l <= serve_x;
            ball_x_r <= serve_x + SZ_M1;
          end
        end
        PLAY: begin
          if (frame_tick) begin
            dx_pos   <= dx_n;
            dy_down  <= dy_n;
            ball_x_l <= nx;
            ball_x_r <= nx + SZ_M1;
            ball_y_t <= ny;
            ball_y_b <= ny + SZ_M1;
          end
        end
        MISS: begin
          if (lives != 2'd0) lives <= lives - 2'd1;
          if (lives > 2'd1) begin
            ball_x_l <= SERVE_X;
            ball_x_r <= SERVE_X + SZ_M1;
            ball_y_t <= SERVE_Y;
            ball_y_b <= SERVE_Y + SZ_M1;
            dx_pos   <= 1'b1;
            dy_down  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ball_on = (pix_x >= ball_x_l) && (pix_x <= ball_x_r) &&
                   (pix_y >= ball_y_t) && (pix_y <= ball_y_b);
endmodule

// File: tb/tb_breakout_ball_ctrl.sv
// Bench for breakout_ball_ctrl: directed game script plus random play against an integer reference model.
module tb_breakout_ball_ctrl;
  logic        clk;
  logic        reset, frame_tick, launch, moveU, moveD, moveL, moveR;
  logic [10:0] paddle_x_l, paddle_x_r, pix_x, pix_y;
  logic [10:0] ball_x_l, ball_x_r, ball_y_t, ball_y_b;
  logic        ball_on, game_over;
  logic [1:0]  lives;

  breakout_ball_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch(launch),
    .moveU(moveU), .moveD(moveD), .moveL(moveL), .moveR(moveR),
    .paddle_x_l(paddle_x_l), .paddle_x_r(paddle_x_r), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(ball_x_l), .ball_x_r(ball_x_r), .ball_y_t(ball_y_t), .ball_y_b(ball_y_b),
    .ball_on(ball_on), .lives(lives), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: signed velocities, integer positions.
  localparam int M_SERVE = 0, M_PLAY = 1, M_MISS = 2, M_OVER = 3;
  int m_mode, m_x, m_y, m_dx, m_dy, m_lives, m_px, m_py;
  bit p_u, p_d, p_l, p_r;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_SERVE; m_x = 396; m_y = 562; m_dx = 1; m_dy = -1; m_lives = 3;
    p_u = 0; p_d = 0; p_l = 0; p_r = 0;
  endtask

  task automatic model_step();
    int pl, pr;
    pl = int'(paddle_x_l);
    pr = int'(paddle_x_r);
    case (m_mode)
      M_SERVE: begin
        if (launch) begin
          m_mode = M_PLAY; m_dx = 1; m_dy = -1;
        end else if (frame_tick) m_x = (pl + pr) / 2 - 4;
      end
      M_PLAY: begin
        p_u = p_u | moveU; p_d = p_d | moveD; p_l = p_l | moveL; p_r = p_r | moveR;
        if (frame_tick) begin
          if (p_r && p_l) m_dx = -m_dx; else if (p_r) m_dx = 1; else if (p_l) m_dx = -1;
          if (p_d && p_u) m_dy = -m_dy; else if (p_d) m_dy = 1; else if (p_u) m_dy = -1;
          if (m_x <= 2 && m_dx < 0) m_dx = 1;
          else if (m_x + 7 >= 797 && m_dx > 0) m_dx = -1;
          if (m_y <= 2 && m_dy < 0) m_dy = 1;
          if (m_dy > 0 && m_y + 7 >= 568 && m_y + 7 <= 570 && m_x + 7 >= pl && m_x <= pr) m_dy = -1;
          m_x = m_x + 2 * m_dx;
          if (m_x < 0) m_x = 0;
          if (m_x > 792) m_x = 792;
          m_y = m_y + 2 * m_dy;
          if (m_y < 0) m_y = 0;
          p_u = 0; p_d = 0; p_l = 0; p_r = 0;
          if (m_y > 599) m_mode = M_MISS;
        end
      end
      M_MISS: begin
        if (m_lives > 0) m_lives--;
        if (m_lives == 0) m_mode = M_OVER;
        else begin
          m_mode = M_SERVE; m_x = 396; m_y = 562; m_dx = 1; m_dy = -1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("x_l", int'(ball_x_l), m_x);
    check("x_r", int'(ball_x_r), m_x + 7);
    check("y_t", int'(ball_y_t), m_y);
    check("y_b", int'(ball_y_b), m_y + 7);
    check("lives", int'(lives), m_lives);
    check("game_over", int'(game_over), (m_mode == M_OVER) ? 1 : 0);
    check("ball_on", int'(ball_on),
          (m_px >= m_x && m_px <= m_x + 7 && m_py >= m_y && m_py <= m_y + 7) ? 1 : 0);
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge.
  task automatic cycle(input logic t, input logic l, input logic [3:0] mv);
    frame_tick = t; launch = l;
    {moveU, moveD, moveL, moveR} = mv;
    model_step();
    m_px = m_x + int'($urandom_range(0, 13)) - 3;
    m_py = m_y + int'($urandom_range(0, 13)) - 3;
    if (m_px < 0) m_px = 0;
    if (m_py < 0) m_py = 0;
    pix_x = 11'(m_px);
    pix_y = 11'(m_py);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Reset lands mid-cycle with tick/launch/moves held high across an edge; all must be ignored.
  task automatic do_reset();
    #2;
    reset = 1; frame_tick = 1; launch = 1;
    {moveU, moveD, moveL, moveR} = 4'b1111;
    #1;
    model_reset();
    check("rst_x_l", int'(ball_x_l), 396);
    check("rst_y_t", int'(ball_y_t), 562);
    check("rst_lives", int'(lives), 3);
    check("rst_over", int'(game_over), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 0; frame_tick = 0; launch = 0;
    {moveU, moveD, moveL, moveR} = 4'b0000;
    compare_all();
  endtask

  task automatic rand_paddle();
    if ($urandom_range(0, 3) == 0) begin
      paddle_x_l = 11'd10; paddle_x_r = 11'd799;
    end else begin
      int pl, pr;
      pl = int'($urandom_range(10, 700));
      pr = pl + int'($urandom_range(20, 99));
      if (pr > 799) pr = 799;
      paddle_x_l = 11'(pl); paddle_x_r = 11'(pr);
    end
  endtask

  initial begin
    int frozen_x;
    reset = 1; frame_tick = 0; launch = 0;
    {moveU, moveD, moveL, moveR} = 4'b0000;
    paddle_x_l = 11'd360; paddle_x_r = 11'd440;
    pix_x = '0; pix_y = '0; m_px = 0; m_py = 0;
    @(negedge clk);
    do_reset();

    cycle(1, 0, 4'b0000);
    check("serve_center", int'(ball_x_l), 396);
    cycle(1, 1, 4'b0000);
    check("launch_tick_x", int'(ball_x_l), 396);
    check("launch_tick_y", int'(ball_y_t), 562);
    cycle(1, 0, 4'b0000);
    check("first_move_x", int'(ball_x_l), 398);
    check("first_move_y", int'(ball_y_t), 560);

    cycle(0, 0, 4'b0010);
    repeat (4) cycle(0, 0, 4'b0000);
    cycle(1, 0, 4'b0000);
    check("move_l_x", int'(ball_x_l), 396);
    cycle(1, 0, 4'b0000);
    check("keep_left_x", int'(ball_x_l), 394);

    cycle(0, 0, 4'b0010);
    cycle(0, 0, 4'b0001);
    cycle(1, 0, 4'b0000);
    check("both_lr_flip", int'(ball_x_l), 396);

    cycle(1, 0, 4'b0100);
    repeat (3) cycle(1, 0, 4'b0000);
    check("pre_paddle_yb", int'(ball_y_b), 569);
    cycle(1, 0, 4'b0000);
    check("paddle_bounce_y", int'(ball_y_t), 560);

    cycle(1, 0, 4'b0100);
    paddle_x_l = 11'd0; paddle_x_r = 11'd100;
    for (int k = 0; k < 40 && m_mode != M_MISS; k++) cycle(1, 0, 4'b0000);
    check("miss_y_below", (ball_y_t > 11'd599) ? 1 : 0, 1);
    cycle(0, 0, 4'b0000);
    check("miss_lives", int'(lives), 2);
    check("reserve_y", int'(ball_y_t), 562);

    for (int g = 0; g < 2; g++) begin
      cycle(0, 1, 4'b0000);
      cycle(1, 0, 4'b0100);
      for (int k = 0; k < 40 && m_mode != M_MISS; k++) cycle(1, 0, 4'b0000);
      cycle(0, 0, 4'b0000);
    end
    check("over_flag", int'(game_over), 1);
    check("over_lives", int'(lives), 0);
    frozen_x = m_x;
    for (int k = 0; k < 30; k++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    check("frozen_x", int'(ball_x_l), frozen_x);
    do_reset();

    for (int g = 0; g < 6; g++) begin
      rand_paddle();
      for (int c = 0; c < 4500; c++) begin
        if (c % 500 == 499) rand_paddle();
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0,
              {$urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0});
      end
      do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
